generic_norm_shift: RTL and testbench

GENERIC_NORM_SHIFT -- requirements
Module: generic_norm_shift

---
 rtl/generic_norm_shift.sv | 124 ++++++++++++
 tb/tb_generic_norm_shift.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_norm_shift.sv
// Two-stage valid/ready normalizer: shifts a mantissa left by its leading-zero
// count, limited by the exponent so the result never drops below exponent 0.
module generic_norm_shift #(
    parameter  int DW    = 16,
    parameter  int EW    = 8,
    localparam int IDX_W = (DW > 2) ? $clog2(DW - 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_mant,
    input  logic [EW-1:0]    in_exp,
    input  logic [IDX_W-1:0] in_lzc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_mant,
    output logic [EW-1:0]    out_exp,
    output logic             out_zero,
    output logic             out_uflow
);

    // Shift count and exponent are compared in a width that holds both without truncation.
    localparam int             CW     = (EW > IDX_W + 1) ? EW : IDX_W + 1;
    localparam logic [CW-1:0]  LZ_MAX = CW'(DW - 1);

    logic             r_s1_valid;
    logic [DW-1:0]    r_s1_mant;
    logic [EW-1:0]    r_s1_exp;
    logic [IDX_W-1:0] r_s1_lzc;
    logic             r_s1_zero;

    logic             r_s2_valid;
    logic [DW-1:0]    r_s2_mant;
    logic [EW-1:0]    r_s2_exp;
    logic             r_s2_zero;
    logic             r_s2_uflow;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [CW-1:0]    w_lz;
    logic [CW-1:0]    w_exp_ext;
    logic [CW-1:0]    w_sh;
    logic             w_uflow;
    logic [DW-1:0]    w_mant_nx;
    logic [EW-1:0]    w_exp_nx;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_lz      = CW'(r_s1_lzc);
        w_exp_ext = CW'(r_s1_exp);
        w_sh      = '0;
        w_uflow   = 1'b0;
        w_mant_nx = '0;
        w_exp_nx  = '0;
        if (w_lz > LZ_MAX) begin
            w_lz = LZ_MAX;
        end
        if (w_lz > w_exp_ext) begin
            w_sh    = w_exp_ext;
            w_uflow = 1'b1;
        end else begin
            w_sh    = w_lz;
        end
        w_mant_nx = r_s1_mant << w_sh;
        w_exp_nx  = r_s1_exp - EW'(w_sh);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
        end
    end

    // NOTE: S1 payload has no reset; its valid bit alone decides whether the contents mean anything.
    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_s1_mant <= in_mant;
            r_s1_exp  <= in_exp;
            r_s1_lzc  <= in_lzc;
            r_s1_zero <= (in_mant == '0);
        end
    end

    // S2 payload is reset because it drives the outputs, which must read zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_mant  <= '0;
            r_s2_exp   <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_uflow <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_zero) begin
                    r_s2_mant  <= '0;
                    r_s2_exp   <= '0;
                    r_s2_zero  <= 1'b1;
                    r_s2_uflow <= 1'b0;
                end else begin
                    r_s2_mant  <= w_mant_nx;
                    r_s2_exp   <= w_exp_nx;
                    r_s2_zero  <= 1'b0;
                    r_s2_uflow <= w_uflow;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_mant  = r_s2_mant;
    assign out_exp   = r_s2_exp;
    assign out_zero  = r_s2_zero;
    assign out_uflow = r_s2_uflow;

endmodule

// File: tb/tb_generic_norm_shift.sv
// Self-checking bench for generic_norm_shift: directed vectors, back-pressure,
// reset and randomized streaming against an arithmetic reference model.
module tb_generic_norm_shift;

    localparam int DW    = 16;
    localparam int EW    = 8;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_mant;
    logic [EW-1:0]    in_exp;
    logic [IDX_W-1:0] in_lzc;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_mant;
    logic [EW-1:0]    out_exp;
    logic             out_zero;
    logic             out_uflow;

    always #5 clk = ~clk;

    generic_norm_shift #(.DW(DW), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_lzc    (in_lzc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
    );

    typedef struct {
        logic [DW-1:0] mant;
        logic [EW-1:0] exp;
        logic          zero;
        logic          uflow;
    } res_t;

    res_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input logic [DW-1:0] m, input logic [EW-1:0] e,
                                   input logic [IDX_W-1:0] l);
        res_t r;
        int   lz;
        int   ev;
        int   sh;
        lz = (int'(l) > DW - 1) ? DW - 1 : int'(l);
        ev = int'(e);
        if (m == '0) begin
            r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0;
            return r;
        end
        sh      = (lz < ev) ? lz : ev;
        r.mant  = m << sh;
        r.exp   = EW'(ev - sh);
        r.zero  = 1'b0;
        r.uflow = (lz > ev);
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] clz(input logic [DW-1:0] m);
        for (int i = DW - 1; i >= 0; i--) begin
            if (m[i]) return IDX_W'(DW - 1 - i);
        end
        return IDX_W'(DW - 1);
    endfunction

    // One clock cycle: drive, observe transfers just before the edge, end at the next negedge.
    task automatic step(input logic iv, input logic [DW-1:0] m, input logic [EW-1:0] e,
                        input logic [IDX_W-1:0] l, input logic ordy,
                        output logic acc, output logic popped);
        res_t r;
        in_valid  = iv;
        in_mant   = m;
        in_exp    = e;
        in_lzc    = l;
        out_ready = ordy;
        #1;
        acc    = in_valid && in_ready;
        popped = out_valid && out_ready;
        if (popped) begin
            check("out_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                r = q.pop_front();
                check("out_mant",  32'(out_mant),  32'(r.mant));
                check("out_exp",   32'(out_exp),   32'(r.exp));
                check("out_zero",  32'(out_zero),  32'(r.zero));
                check("out_uflow", 32'(out_uflow), 32'(r.uflow));
            end
        end
        if (acc) q.push_back(model(m, e, l));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [DW-1:0] m, input logic [EW-1:0] e,
                            input logic [IDX_W-1:0] l, input logic [DW-1:0] x_mant,
                            input logic [EW-1:0] x_exp, input logic x_zero, input logic x_uflow);
        logic acc;
        logic pop;
        step(1'b1, m, e, l, 1'b1, acc, pop);
        check({tag, "_acc"}, 32'(acc), 32'd1);
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step(1'b0, '0, '0, '0, 1'b1, acc, pop);
        check({tag, "_lat2"},  32'(out_valid), 32'd1);
        check({tag, "_mant"},  32'(out_mant),  32'(x_mant));
        check({tag, "_exp"},   32'(out_exp),   32'(x_exp));
        check({tag, "_zero"},  32'(out_zero),  32'(x_zero));
        check({tag, "_uflow"}, 32'(out_uflow), 32'(x_uflow));
        step(1'b0, '0, '0, '0, 1'b1, acc, pop);
        check({tag, "_pop"}, 32'(pop), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic          pop;
        logic [DW-1:0] m;
        logic [EW-1:0] e;
        logic          iv;
        logic          ordy;
        int            accepted;

        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_lzc = '0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_mant",  32'(out_mant),  32'd0);
        check("rst_out_exp",   32'(out_exp),   32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        check("rst_out_uflow", 32'(out_uflow), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        directed("normal", 16'h0010, 8'd20, 4'd11, 16'h8000, 8'd9, 1'b0, 1'b0);
        directed("uflow",  16'h0001, 8'd5,  4'd15, 16'h0020, 8'd0, 1'b0, 1'b1);
        directed("zero",   16'h0000, 8'd77, 4'd15, 16'h0000, 8'd0, 1'b1, 1'b0);
        directed("exp_eq", 16'h0100, 8'd7,  4'd7,  16'h8000, 8'd0, 1'b0, 1'b0);

        // Back-pressure: two accepted, third refused, first result held.
        step(1'b1, 16'h1234, 8'd40, clz(16'h1234), 1'b0, acc, pop);
        check("bp_acc0", 32'(acc), 32'd1);
        step(1'b1, 16'h0081, 8'd3, clz(16'h0081), 1'b0, acc, pop);
        check("bp_acc1", 32'(acc), 32'd1);
        step(1'b1, 16'h0000, 8'd9, 4'd15, 1'b0, acc, pop);
        check("bp_ready_drop", 32'(acc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_mant",  32'(out_mant),  32'(q[0].mant));
            check("bp_hold_exp",   32'(out_exp),   32'(q[0].exp));
            step(1'b1, 16'h0000, 8'd9, 4'd15, 1'b0, acc, pop);
            check("bp_still_refused", 32'(acc), 32'd0);
        end
        step(1'b1, 16'h0000, 8'd9, 4'd15, 1'b1, acc, pop);
        check("bp_acc2", 32'(acc), 32'd1);
        check("bp_pop0", 32'(pop), 32'd1);
        step(1'b1, 16'h7fff, 8'd200, clz(16'h7fff), 1'b1, acc, pop);
        check("bp_acc3", 32'(acc), 32'd1);
        check("bp_pop1", 32'(pop), 32'd1);
        step(1'b0, '0, '0, '0, 1'b1, acc, pop);
        check("bp_pop2", 32'(pop), 32'd1);
        step(1'b0, '0, '0, '0, 1'b1, acc, pop);
        check("bp_pop3", 32'(pop), 32'd1);
        check("bp_empty", 32'(q.size()), 32'd0);

        // Reset with both stages full and out_ready low.
        step(1'b1, 16'h00f0, 8'd30, clz(16'h00f0), 1'b0, acc, pop);
        step(1'b1, 16'h0003, 8'd2, clz(16'h0003), 1'b0, acc, pop);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready",  32'(in_ready),  32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_mant",  32'(out_mant),  32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, acc, pop);
            check("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        step(1'b1, 16'h0400, 8'd50, clz(16'h0400), 1'b1, acc, pop);
        check("post_rst_acc", 32'(acc), 32'd1);
        check("post_rst_lat1", 32'(out_valid), 32'd0);
        step(1'b0, '0, '0, '0, 1'b1, acc, pop);
        check("post_rst_lat2", 32'(out_valid), 32'd1);
        step(1'b0, '0, '0, '0, 1'b1, acc, pop);
        check("post_rst_pop", 32'(pop), 32'd1);

        // Randomized streaming with random valid and ready.
        accepted = 0;
        for (int cyc = 0; cyc < 3000 && accepted < 100; cyc++) begin
            m    = DW'($urandom) >> $urandom_range(0, DW - 1);
            if ($urandom_range(0, 9) == 0) m = '0;
            e    = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 15)) : EW'($urandom_range(0, 255));
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, m, e, clz(m), ordy, acc, pop);
            if (acc) accepted++;
        end
        for (int cyc = 0; cyc < 50 && q.size() > 0; cyc++) begin
            step(1'b0, '0, '0, '0, 1'b1, acc, pop);
        end
        check("stream_accepted", 32'(accepted), 32'd100);
        check("stream_drained", 32'(q.size()), 32'd0);
        check("stream_idle", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
